// File: rtl/clk_div.sv
// rtl/clk_div.sv - integer clock divider with reference-clock bypass
//
// Divides i_ref_clk by any ratio N in [2, 2**RATIO_WD - 1], odd or even.
// For N = 0, N = 1 or i_clk_en = 0 the reference clock is passed straight
// through.
//
// Ports:
//   i_ref_clk   - reference clock; all state updates on its rising edge
//   i_rst       - asynchronous active-high reset (release is synchronous upstream)
//   i_clk_en    - 1: divide, 0: bypass
//   i_div_ratio - division ratio N, quasi-static, may change at run time
//   o_div_clk   - divided clock, or i_ref_clk in bypass

module clk_div #(
    parameter int RATIO_WD = 8
) (
    input  logic                i_ref_clk,
    input  logic                i_rst,
    input  logic                i_clk_en,
    input  logic [RATIO_WD-1:0] i_div_ratio,
    output logic                o_div_clk
);

    localparam int CNT_WD = RATIO_WD - 1;

    logic [CNT_WD-1:0] cnt_q;
    logic [CNT_WD-1:0] cnt_d;
    logic              div_q;
    logic              div_d;

    logic              bypass;
    logic [CNT_WD-1:0] half;
    logic [CNT_WD-1:0] thresh;

    // N = 0 and N = 1 both have a zero upper part; no divide is meaningful.
    assign bypass = !i_clk_en || (i_div_ratio[RATIO_WD-1:1] == '0);
    assign half   = i_div_ratio[RATIO_WD-1:1];

    // Odd N stretches the high phase by one cycle: low = floor(N/2),
    // high = ceil(N/2). Even N uses the same threshold in both phases.
    assign thresh = (div_q && i_div_ratio[0]) ? half : (half - CNT_WD'(1));

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        if (bypass) begin
            // Hold at reset values so divide mode always starts from cnt = 0.
            cnt_d = '0;
            div_d = 1'b0;
        end else if (cnt_q >= thresh) begin
            // >= rather than == so a shrinking N toggles on the next edge
            // instead of letting the counter run away.
            cnt_d = '0;
            div_d = !div_q;
        end else begin
            cnt_d = cnt_q + CNT_WD'(1);
        end
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
            div_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

    // Only combinational path to the output; a glitch on a mode switch is
    // tolerated because downstream logic does not switch mode while running.
    assign o_div_clk = bypass ? i_ref_clk : div_q;

endmodule

// File: tb/tb_clk_div.sv
// tb/tb_clk_div.sv - self-checking bench for clk_div

`timescale 1ns/1ps

module tb_clk_div;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] ratio;
    logic       div_clk;

    int checks;
    int errors;
    logic sb[$];

    clk_div #(.RATIO_WD(8)) dut (
        .i_ref_clk  (clk),
        .i_rst      (rst),
        .i_clk_en   (en),
        .i_div_ratio(ratio),
        .o_div_clk  (div_clk)
    );

    initial clk = 1'b0;
    always #135.635 clk = ~clk;

    // Value after the k-th rising edge following reset release:
    // first floor(N/2) positions low, remaining ceil(N/2) high, period N.
    task automatic push_pattern(input int n, input int first_k, input int count);
        for (int k = first_k; k < first_k + count; k++)
            sb.push_back(((k % n) >= (n / 2)) ? 1'b1 : 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic exp;
        en = 1'b1;
        ratio = 8'd2;
        rst = 1'b1;
        #3;
        checks++;
        if (div_clk !== 1'b0) begin
            errors++;
            $display("FAIL reset_div_start: got %b expected 0", div_clk);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (div_clk !== 1'b0) begin
                errors++;
                $display("FAIL reset_div_hold cycle %0d: got %b expected 0", i, div_clk);
            end
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            exp = 1'b1;
            checks++;
            if (div_clk !== exp) begin
                errors++;
                $display("FAIL reset_bypass_high cycle %0d: got %b expected %b", i, div_clk, exp);
            end
            @(negedge clk);
            #1;
            exp = 1'b0;
            checks++;
            if (div_clk !== exp) begin
                errors++;
                $display("FAIL reset_bypass_low cycle %0d: got %b expected %b", i, div_clk, exp);
            end
        end
        en = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_ratio(input int n, input int periods);
        logic exp;
        int   cycles;
        en = 1'b1;
        ratio = 8'(n);
        do_reset();
        cycles = n * periods;
        push_pattern(n, 1, cycles);
        for (int k = 1; k <= cycles; k++) begin
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            checks++;
            if (div_clk !== exp) begin
                errors++;
                $display("FAIL ratio_%0d edge %0d: got %b expected %b", n, k, div_clk, exp);
            end
        end
    endtask

    task automatic test_bypass();
        logic       exp;
        logic [7:0] ratios [3];
        logic       ens    [3];
        ratios[0] = 8'd0; ens[0] = 1'b1;
        ratios[1] = 8'd1; ens[1] = 1'b1;
        ratios[2] = 8'd8; ens[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2;
            ratio = ratios[c];
            en = ens[c];
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1;
                exp = 1'b1;
                checks++;
                if (div_clk !== exp) begin
                    errors++;
                    $display("FAIL bypass_n%0d_en%0d_high: got %b expected %b", ratios[c], ens[c], div_clk, exp);
                end
                @(negedge clk);
                #1;
                exp = 1'b0;
                checks++;
                if (div_clk !== exp) begin
                    errors++;
                    $display("FAIL bypass_n%0d_en%0d_low: got %b expected %b", ratios[c], ens[c], div_clk, exp);
                end
            end
        end
        @(posedge clk);
        #2;
        en = 1'b1;
        ratio = 8'd8;
        #1;
        checks++;
        if (div_clk !== 1'b0) begin
            errors++;
            $display("FAIL bypass_to_div_immediate: got %b expected 0", div_clk);
        end
        push_pattern(8, 1, 24);
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            checks++;
            if (div_clk !== exp) begin
                errors++;
                $display("FAIL bypass_to_div_n8 edge %0d: got %b expected %b", k, div_clk, exp);
            end
        end
    endtask

    task automatic test_shrink();
        logic exp;
        en = 1'b1;
        ratio = 8'd32;
        do_reset();
        push_pattern(32, 1, 10);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            checks++;
            if (div_clk !== exp) begin
                errors++;
                $display("FAIL shrink_pre edge %0d: got %b expected %b", k, div_clk, exp);
            end
        end
        #1 ratio = 8'd4;
        // Immediate toggle high on the next edge, then high 2 / low 2.
        for (int k = 0; k < 16; k++)
            sb.push_back(((k % 4) < 2) ? 1'b1 : 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            checks++;
            if (div_clk !== exp) begin
                errors++;
                $display("FAIL shrink_post edge %0d: got %b expected %b", k, div_clk, exp);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic exp;
        en = 1'b1;
        ratio = 8'd32;
        do_reset();
        for (int k = 1; k <= 20; k++) @(posedge clk);
        #1;
        checks++;
        if (div_clk !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre_high: got %b expected 1", div_clk);
        end
        @(negedge clk);
        #20 rst = 1'b1;
        #1;
        checks++;
        if (div_clk !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async_clear: got %b expected 0", div_clk);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        push_pattern(32, 1, 40);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            checks++;
            if (div_clk !== exp) begin
                errors++;
                $display("FAIL midreset_restart edge %0d: got %b expected %b", k, div_clk, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        en = 1'b1;
        ratio = 8'd2;
        test_reset();
        test_ratio(2, 6);
        test_ratio(32, 20);
        test_ratio(5, 6);
        test_ratio(3, 6);
        test_ratio(255, 2);
        test_bypass();
        test_shrink();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
